// File: rtl/ex_div_pkg.sv
// rtl/ex_div_pkg.sv - shared divider state, result-ready and DIV/DIVU op constants
package ex_div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_t;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

endpackage

// File: rtl/ex_div.sv
// rtl/ex_div.sv - iterative radix-2 restoring divider for the EX stage
module ex_div
    import ex_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    div_state_t         state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [2*WIDTH:0]   acc, acc_n;          // {partial remainder, quotient being shifted in}
    logic [WIDTH-1:0]   divisor, divisor_n;  // divisor magnitude
    logic               neg_q, neg_q_n;      // quotient must be negated at the final write
    logic               neg_r, neg_r_n;      // remainder takes the dividend's sign
    logic [2*WIDTH-1:0] result_n;
    logic               ready_n;

    logic [2*WIDTH:0]   acc_shift, acc_step;
    logic [WIDTH:0]     window, diff;
    logic               fits;
    logic [WIDTH-1:0]   quo_fin, rem_fin;
    logic [WIDTH-1:0]   mag1, mag2;

    // One shift-subtract step plus operand magnitudes and final sign fix-up
    always_comb begin
        acc_shift = acc << 1;
        window    = acc_shift[2*WIDTH:WIDTH];
        diff      = window - {1'b0, divisor};
        fits      = (window >= {1'b0, divisor});
        acc_step  = acc_shift;
        if (fits) begin
            acc_step[2*WIDTH:WIDTH] = diff;
            acc_step[0]             = 1'b1;
        end
        quo_fin = neg_q ? -acc_step[WIDTH-1:0]       : acc_step[WIDTH-1:0];
        rem_fin = neg_r ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
        mag1    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        mag2    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    end

    // Next-state and next-output decisions for the divide sequence
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        acc_n     = acc;
        divisor_n = divisor;
        neg_q_n   = neg_q;
        neg_r_n   = neg_r;
        result_n  = result_o;
        ready_n   = ready_o;
        case (state)
            DIV_FREE: begin
                if (start_i && !annul_i) begin
                    cnt_n     = '0;
                    acc_n     = {{(WIDTH+1){1'b0}}, mag1};
                    divisor_n = mag2;
                    neg_q_n   = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_r_n   = signed_div_i && opdata1_i[WIDTH-1];
                    state_n   = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                end
            end
            DIV_BYZERO: begin
                if (annul_i) begin
                    state_n = DIV_FREE;
                end else begin
                    result_n = '0;
                    ready_n  = DIV_RESULT_READY;
                    state_n  = DIV_END;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_n = DIV_FREE;
                end else begin
                    acc_n = acc_step;
                    cnt_n = cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        result_n = {rem_fin, quo_fin};
                        ready_n  = DIV_RESULT_READY;
                        state_n  = DIV_END;
                    end
                end
            end
            DIV_END: begin
                // annul is deliberately ignored here: the result is already committed
                if (!start_i) begin
                    result_n = '0;
                    ready_n  = DIV_RESULT_NOT_READY;
                    state_n  = DIV_FREE;
                end
            end
            default: state_n = DIV_FREE;
        endcase
    end

    // State, datapath and registered outputs with asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            acc      <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            acc      <= acc_n;
            divisor  <= divisor_n;
            neg_q    <= neg_q_n;
            neg_r    <= neg_r_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - directed self-checking bench for ex_div
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    ex_div #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic drive_start(input logic s, input logic [31:0] a, input logic [31:0] b);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
    endtask

    // waits for the accept edge, scrambles operands, then counts edges until ready_o
    task automatic wait_ready(output int lat, output logic [63:0] res);
        @(posedge clk);
        #1;
        opdata1_i    = 32'hDEADBEEF;
        opdata2_i    = 32'h00000003;
        signed_div_i = ~signed_div_i;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready_o) begin
                lat = k;
                break;
            end
        end
        res = result_o;
    endtask

    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [63:0] res);
        @(negedge clk);
        drive_start(s, a, b);
        wait_ready(lat, res);
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready_o); end
        checks++;
        if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result got %h want 0", result_o); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_divu_basic;
        int lat;
        logic [63:0] res;
        run_div(1'b0, 32'd100, 32'd7, lat, res);
        checks++;
        if (lat !== 32) begin errors++; $display("FAIL divu_latency got %0d want 32", lat); end
        checks++;
        if (res !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_result got %h want %h", res, {32'd2, 32'd14}); end
        repeat (3) @(negedge clk);
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL divu_hold_ready got %b want 1", ready_o); end
        checks++;
        if (result_o !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_hold_result got %h want %h", result_o, {32'd2, 32'd14}); end
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL divu_drop_ready got %b want 0", ready_o); end
        checks++;
        if (result_o !== 64'd0) begin errors++; $display("FAIL divu_drop_result got %h want 0", result_o); end
    endtask

    task automatic test_signed;
        int lat;
        logic [63:0] res;
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, lat, res);
        start_i = 1'b0;
        checks++;
        if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin errors++; $display("FAIL div_neg_dividend got %h want %h", res, {32'hFFFFFFFF, 32'hFFFFFFFD}); end
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, lat, res);
        start_i = 1'b0;
        checks++;
        if (res !== {32'd1, 32'hFFFFFFFD}) begin errors++; $display("FAIL div_neg_divisor got %h want %h", res, {32'd1, 32'hFFFFFFFD}); end
        checks++;
        if (lat !== 32) begin errors++; $display("FAIL div_signed_latency got %0d want 32", lat); end
    endtask

    task automatic test_overflow;
        int lat;
        logic [63:0] res;
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, res);
        start_i = 1'b0;
        checks++;
        if (res !== {32'd0, 32'h80000000}) begin errors++; $display("FAIL div_overflow got %h want %h", res, {32'd0, 32'h80000000}); end
        run_div(1'b0, 32'h80000000, 32'hFFFFFFFF, lat, res);
        start_i = 1'b0;
        checks++;
        if (res !== {32'h80000000, 32'd0}) begin errors++; $display("FAIL divu_big got %h want %h", res, {32'h80000000, 32'd0}); end
    endtask

    task automatic test_div_zero;
        int lat;
        logic [63:0] res;
        run_div(1'b0, 32'h1234, 32'd0, lat, res);
        start_i = 1'b0;
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL divzero_latency got %0d want 1", lat); end
        checks++;
        if (res !== 64'd0) begin errors++; $display("FAIL divzero_result got %h want 0", res); end
    endtask

    task automatic test_annul;
        int lat;
        logic [63:0] res;
        @(negedge clk);
        drive_start(1'b0, 32'd100, 32'd7);
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL annul_ready got %b want 0", ready_o); end
        drive_start(1'b0, 32'd15, 32'd4);
        wait_ready(lat, res);
        checks++;
        if (lat !== 32) begin errors++; $display("FAIL annul_next_latency got %0d want 32", lat); end
        checks++;
        if (res !== {32'd3, 32'd3}) begin errors++; $display("FAIL annul_next_result got %h want %h", res, {32'd3, 32'd3}); end
        start_i = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        int lat;
        logic [63:0] res;
        int bad;
        @(negedge clk);
        drive_start(1'b0, 32'd100, 32'd7);
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin errors++; $display("FAIL rst_mid_op got ready %b result %h want 0 0", ready_o, result_o); end
        @(negedge clk);
        start_i = 1'b0;
        rst = 1'b1;
        // async clear of a held, nonzero result before any clock edge
        run_div(1'b0, 32'd100, 32'd7, lat, res);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin errors++; $display("FAIL rst_async_end got ready %b result %h want 0 0", ready_o, result_o); end
        @(negedge clk);
        start_i = 1'b0;
        rst = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (ready_o !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL idle_after_rst got %0d ready cycles want 0", bad); end
        drive_start(1'b0, 32'd100, 32'd7);
        annul_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL start_with_annul got %0d ready cycles want 0", bad); end
        run_div(1'b0, 32'd15, 32'd4, lat, res);
        start_i = 1'b0;
        checks++;
        if (lat !== 32 || res !== {32'd3, 32'd3}) begin errors++; $display("FAIL post_rst_div got lat %0d res %h want 32 %h", lat, res, {32'd3, 32'd3}); end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_overflow();
        test_div_zero();
        test_annul();
        test_reset_mid_op();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
